// File: rtl/rr_bus_arb_if.sv
// Request/grant bundle between the masters, the shared slave and the
// round-robin arbiter. The arbiter connects through the slave modport; the
// request/ack side connects through the master modport.
interface rr_bus_arb_if #(
  parameter int NM  = 4,
  parameter int IDW = 2
);
  logic [NM-1:0]  req;
  logic           slv_ack;
  logic [NM-1:0]  gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           tout_err;
  logic [IDW-1:0] tout_id;

  modport master (
    output req, slv_ack,
    input  gnt, gnt_id, busy, tout_err, tout_id
  );

  modport slave (
    input  req, slv_ack,
    output gnt, gnt_id, busy, tout_err, tout_id
  );
endinterface

// File: rtl/rr_bus_arb.sv
// Round-robin arbiter for one shared slave port. A grant stays open until the
// slave acks, the owner drops its request, or TOUT cycles pass without an
// ack. One dead cycle always separates consecutive grants.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no grant open, arbitrating among current requests
// S_GRANT | one master owns the port, timeout counter running
// S_TURN  | one-cycle turnaround after a release, gnt held at zero
module rr_bus_arb #(
  parameter int NM   = 4,
  parameter int IDW  = 2,
  parameter int TOUT = 255,
  parameter int TW   = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_bus_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [TW-1:0]  CNT_LAST = TW'(TOUT - 1);
  localparam logic [TW-1:0]  CNT_MAX  = TW'(TOUT);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NM - 1);

  state_t         r_state;
  logic [NM-1:0]  r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_busy;
  logic           r_tout_err;
  logic [IDW-1:0] r_tout_id;
  logic [IDW-1:0] r_last;
  logic [TW-1:0]  r_cnt;

  logic [IDW-1:0] w_sel;
  logic           w_hit;
  int             w_best;
  int             w_dist;

  // Pick the requester closest after the last grant, wrapping modulo NM.
  always_comb begin
    w_sel  = r_last;
    w_hit  = |bus.req;
    w_best = NM;
    w_dist = 0;
    for (int j = 0; j < NM; j++) begin
      if (bus.req[j]) begin
        w_dist = (j + NM - 1 - int'(r_last)) % NM;
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_sel  = IDW'(j);
        end
      end
    end
  end

  // Arbitration FSM with registered grant, status and timeout outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_tout_err <= 1'b0;
      r_tout_id  <= '0;
      r_last     <= ID_LAST;
      r_cnt      <= '0;
    end else begin
      r_tout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_gnt    <= NM'(1) << w_sel;
            r_gnt_id <= w_sel;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          // ack beats abort beats timeout
          if (bus.slv_ack || !bus.req[r_gnt_id]) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_gnt_id;
            r_cnt   <= '0;
            r_state <= S_TURN;
          end else if (r_cnt == CNT_LAST) begin
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_last     <= r_gnt_id;
            r_cnt      <= '0;
            r_tout_err <= 1'b1;
            r_tout_id  <= r_gnt_id;
            r_state    <= S_TURN;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TURN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.gnt_id   = r_gnt_id;
  assign bus.busy     = r_busy;
  assign bus.tout_err = r_tout_err;
  assign bus.tout_id  = r_tout_id;

endmodule

// File: tb/tb_rr_bus_arb.sv
// Random-stimulus bench for rr_bus_arb: a 4-master instance with a short
// timeout and a 3-master instance, both compared each cycle against a
// transaction-level round-robin model.
module tb_rr_bus_arb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_bus_arb_if #(.NM(4), .IDW(2)) bus4();
  rr_bus_arb_if #(.NM(3), .IDW(2)) bus3();

  rr_bus_arb #(.NM(4), .IDW(2), .TOUT(5), .TW(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  rr_bus_arb #(.NM(3), .IDW(2), .TOUT(7), .TW(4)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int total = 0;
  int bad   = 0;

  int nm   [2] = '{4, 3};
  int tout [2] = '{5, 7};

  // model: who owns the port, how many cycles it has been open, pending
  // turnaround, round-robin pointer and error reporting
  int m_owner [2];
  int m_open  [2];
  bit m_cool  [2];
  int m_last  [2];
  bit m_err   [2];
  int m_tid   [2];
  int rq      [2];
  bit ack     [2];

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic model_step(input int d, input bit rstv);
    int c;
    if (!rstv) begin
      m_owner[d] = -1;
      m_open[d]  = 0;
      m_cool[d]  = 0;
      m_err[d]   = 0;
      m_tid[d]   = 0;
      m_last[d]  = nm[d] - 1;
    end else begin
      m_err[d] = 0;
      if (m_owner[d] >= 0) begin
        if (ack[d] || !((rq[d] >> m_owner[d]) & 1)) begin
          m_last[d]  = m_owner[d];
          m_owner[d] = -1;
          m_cool[d]  = 1;
        end else if (m_open[d] + 1 == tout[d]) begin
          m_err[d]   = 1;
          m_tid[d]   = m_owner[d];
          m_last[d]  = m_owner[d];
          m_owner[d] = -1;
          m_cool[d]  = 1;
        end else begin
          m_open[d]++;
        end
      end else if (m_cool[d]) begin
        m_cool[d] = 0;
      end else if (rq[d] != 0) begin
        for (int k = 1; k <= nm[d]; k++) begin
          c = (m_last[d] + k) % nm[d];
          if ((rq[d] >> c) & 1) begin
            m_owner[d] = c;
            break;
          end
        end
        m_open[d] = 0;
      end
    end
  endtask

  task automatic check_outputs(input int d, input int cyc);
    logic [31:0] g, gid, b, e, tid;
    if (d == 0) begin
      g = 32'(bus4.gnt); gid = 32'(bus4.gnt_id); b = 32'(bus4.busy);
      e = 32'(bus4.tout_err); tid = 32'(bus4.tout_id);
    end else begin
      g = 32'(bus3.gnt); gid = 32'(bus3.gnt_id); b = 32'(bus3.busy);
      e = 32'(bus3.tout_err); tid = 32'(bus3.tout_id);
    end
    chk_val($sformatf("d%0d c%0d gnt", d, cyc), g,
            (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0);
    chk_val($sformatf("d%0d c%0d busy", d, cyc), b, (m_owner[d] >= 0) ? 32'd1 : 32'd0);
    chk_val($sformatf("d%0d c%0d tout_err", d, cyc), e, 32'(m_err[d]));
    chk_val($sformatf("d%0d c%0d tout_id", d, cyc), tid, 32'(m_tid[d]));
    if (m_owner[d] >= 0)
      chk_val($sformatf("d%0d c%0d gnt_id", d, cyc), gid, 32'(m_owner[d]));
  endtask

  task automatic pick_inputs(input int d, input int mode);
    int v;
    v = rq[d];
    for (int i = 0; i < nm[d]; i++) begin
      if (mode == 3) begin
        v = v | (1 << i);
      end else if (i == m_owner[d]) begin
        if ($urandom_range(19) == 0) v = v & ~(1 << i);
      end else if ($urandom_range(5) == 0) begin
        v = v ^ (1 << i);
      end
    end
    rq[d] = v;
    case (mode)
      0:       ack[d] = ($urandom_range(3) == 0);
      1:       ack[d] = 1'b0;
      2:       ack[d] = (m_owner[d] >= 0) && (m_open[d] + 1 == tout[d]);
      default: ack[d] = ($urandom_range(1) == 0);
    endcase
    if (d == 0) begin
      bus4.req     = 4'(rq[0]);
      bus4.slv_ack = ack[0];
    end else begin
      bus3.req     = 3'(rq[1]);
      bus3.slv_ack = ack[1];
    end
  endtask

  initial begin
    bit r;
    int mode;
    rst          = 1'b1;
    bus4.req     = '0;
    bus4.slv_ack = 1'b0;
    bus3.req     = '0;
    bus3.slv_ack = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rq[d]  = 0;
      ack[d] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      mode = cyc / 500;
      if (cyc > 0) begin
        for (int d = 0; d < 2; d++) check_outputs(d, cyc);
      end
      r = !((cyc < 2) || ($urandom_range(249) == 0));
      rst = r;
      for (int d = 0; d < 2; d++) begin
        pick_inputs(d, mode);
        model_step(d, r);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_outputs(d, 2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_bus_arb.md
Name: rr_bus_arb

Overview:
- Round-robin arbiter that shares one bus/memory slave port between NM masters (e.g. instruction fetch, data load/store, debug).
- Grants the port to one master at a time and holds the grant until the slave reports completion or a timeout fires.
- Enforces one turnaround cycle between grants.
- All outputs are registered; the block sits between the masters' request logic and the shared slave mux.

Parameters:
- NM, 4, number of requesting masters (2..8).
- IDW, 2, width of the grant index output; must satisfy 2**IDW >= NM.
- TOUT, 255, maximum cycles a grant may stay open without slv_ack (1..2**TW-1).
- TW, 8, width of the timeout counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  reset: synchronous, active-low.
- req  input  NM  per-master request, level; held by the master until its transaction completes.
- slv_ack  input  1  slave completion pulse for the current granted transaction.
- gnt  output  NM  one-hot grant, registered, all-zero when idle.
- gnt_id  output  IDW  binary index of the granted master; valid only while busy=1.
- busy  output  1  high while a grant is open.
- tout_err  output  1  one-cycle pulse when a grant is closed by timeout.
- tout_id  output  IDW  index of the master that timed out; updated with tout_err, held otherwise.

Behaviour:
- Reset (rst=0 at a posedge):
  - State is IDLE; gnt=0, gnt_id=0, busy=0, tout_err=0, tout_id=0, timeout counter=0.
  - Last-grant pointer is NM-1, so master 0 has top priority after reset.
  - Reset asserted mid-grant drops the grant at that edge; no tout_err is generated.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req is nonzero, select the first requesting index searching upward from (last+1) mod NM with wrap-around.
  - At the next edge: gnt=onehot(sel), gnt_id=sel, busy=1, counter=0, go to GRANT.
  - Latency from req rising to gnt is 1 cycle.
  - If req=0, stay in IDLE.
- GRANT:
  - Each cycle without slv_ack, the counter increments (saturating at TOUT).
  - Release conditions are evaluated with priority: slv_ack, then abort, then timeout.
  - slv_ack=1: at the edge, gnt=0, busy=0, last=gnt_id, go to TURN.
  - Abort (req[gnt_id]=0 and slv_ack=0): release the same way; no error.
  - Timeout (counter==TOUT-1 and slv_ack=0, i.e. TOUT cycles of grant with no ack): release; tout_err=1 for exactly one cycle; tout_id=gnt_id; last=gnt_id.
  - slv_ack and timeout in the same cycle: ack wins, tout_err stays 0.
  - Requests from other masters are ignored while in GRANT. No preemption.
- TURN:
  - Lasts one cycle with gnt=0, then go to IDLE. This guarantees at least one dead cycle between consecutive grants.
  - Arbitration resumes in IDLE using the updated pointer.
  - The minimum grant-to-grant period is therefore 1 (GRANT) + 1 (TURN) + 1 (IDLE).
- slv_ack outside GRANT is ignored.
- Fairness:
  - Every continuously requesting master is granted within NM grants.
  - The same master never receives two consecutive grants while another master is requesting.
- gnt is always one-hot or zero; gnt_id equals the index of the set bit.
- Arithmetic:
  - Counter is TW-bit unsigned and never wraps.
  - Index arithmetic is modulo NM (non-power-of-two NM must wrap correctly, e.g. NM=3: 2 -> 0).

Test Plan:
- Reset then req=4'b1111, ack 2 cycles after each grant -> grants in order 0,1,2,3,0; each gnt 1-hot; gnt=0 in each TURN cycle.
- req=4'b0100 only, ack 3 cycles after grant -> gnt=4'b0100 one cycle after req, busy=1 until ack edge, 1 TURN cycle, no tout_err.
- TOUT=5, req=4'b0010, never ack -> gnt held exactly 5 cycles; tout_err=1 for 1 cycle with tout_id=1; next grant starts from index 2.
- slv_ack asserted in the same cycle the counter hits TOUT-1 -> grant released, tout_err stays 0.
- Master 3 granted, then req[3] dropped with no ack -> release next edge, no error; pending req[0] granted after TURN+IDLE.
- rst pulsed low while gnt=4'b1000 -> next edge gnt=0, busy=0, tout_err=0; with req=4'b1111 the first post-reset grant goes to master 0.
- NM=3, req=3'b111 -> grant order 0,1,2,0.
